// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU writeback/status stage.
// Holds the architectural N/Z/C flags (C feeds back as ALU carry-in), a sticky
// illegal-opcode flag, and a 2-entry FIFO in front of the register-file write port.
module alu_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_cout,
    input  logic              in_neg,
    input  logic              in_zero,
    input  logic [3:0]        in_opcode,
    input  logic [RD_W-1:0]   in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              err,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam logic [3:0] OP_CMP      = 4'b0111;
    localparam logic [3:0] OP_LAST_LEG = 4'b1000;

    buf_state_e          buf_q;
    logic [DATA_W-1:0]   slot0_data_q, slot1_data_q;
    logic [RD_W-1:0]     slot0_rd_q, slot1_rd_q;
    logic                flag_n_q, flag_z_q, flag_c_q, err_q;
    logic                flag_n_d, flag_z_d, flag_c_d, err_d;

    logic accept, legal, sets_c, push, pop;

    // Handshake qualifiers; in_ready depends only on state and reset.
    assign in_ready = (buf_q != FULL) && !rst;
    assign accept   = in_valid && in_ready;
    assign legal    = (in_opcode <= OP_LAST_LEG);
    assign sets_c   = (in_opcode == 4'b0000) || (in_opcode == 4'b0001) || (in_opcode == 4'b0101);
    assign push     = accept && legal && (in_opcode != OP_CMP);
    assign pop      = wb_valid && wb_ready;

    // Next-state for status flags and the sticky error bit.
    always_comb begin
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        err_d    = err_q;
        if (accept) begin
            if (legal) begin
                flag_n_d = in_neg;
                flag_z_d = in_zero;
                if (sets_c) begin
                    flag_c_d = in_cout;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Status register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            err_q    <= err_d;
        end
    end

    // Writeback buffer FSM: slot0 is always the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q        <= EMPTY;
            slot0_data_q <= '0;
            slot0_rd_q   <= '0;
            slot1_data_q <= '0;
            slot1_rd_q   <= '0;
        end else begin
            case (buf_q)
                EMPTY: begin
                    if (push) begin
                        slot0_data_q <= in_result;
                        slot0_rd_q   <= in_rd;
                        buf_q        <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b11: begin
                            // head leaves and the new entry replaces it directly
                            slot0_data_q <= in_result;
                            slot0_rd_q   <= in_rd;
                        end
                        2'b10: begin
                            slot1_data_q <= in_result;
                            slot1_rd_q   <= in_rd;
                            buf_q        <= FULL;
                        end
                        2'b01: begin
                            buf_q <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        slot0_data_q <= slot1_data_q;
                        slot0_rd_q   <= slot1_rd_q;
                        buf_q        <= ONE;
                    end
                end
                default: buf_q <= EMPTY;
            endcase
        end
    end

    assign wb_valid = (buf_q != EMPTY);
    assign wb_data  = slot0_data_q;
    assign wb_rd    = slot0_rd_q;
    assign count    = buf_q;
    assign flag_n   = flag_n_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign err      = err_q;

endmodule
